// File: rtl/face_detect_sdiv_pkg.sv
// Shared widths, iteration count and FSM state encoding for the face-detect
// 25s/9s sequential signed divider.
package face_detect_sdiv_pkg;

    localparam int DVD_W = 25;
    localparam int DVS_W = 9;
    localparam int ITERS = 25;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

endpackage

// File: rtl/face_detect_sdiv_step.sv
// One radix-2 restoring division step on magnitudes: shift in a dividend bit,
// trial-subtract the divisor and keep the difference only if it is non-negative.
module face_detect_sdiv_step
    import face_detect_sdiv_pkg::*;
(
    input  logic [DVS_W:0] prem,
    input  logic           dividend_bit,
    input  logic [DVS_W:0] dmag,
    output logic [DVS_W:0] next_prem,
    output logic           qbit
);

    logic [DVS_W+1:0] shifted;
    logic [DVS_W+1:0] trial;

    // The partial remainder stays below the divisor, so the shifted value fits
    // one extra bit and the trial's MSB acts as the borrow flag.
    assign shifted   = {prem, dividend_bit};
    assign trial     = shifted - {1'b0, dmag};
    assign qbit      = ~trial[DVS_W+1];
    assign next_prem = qbit ? trial[DVS_W:0] : shifted[DVS_W:0];

endmodule

// File: rtl/face_detect_sdiv_25s_9s_seq.sv
// Iterative signed divider (25-bit dividend / 9-bit divisor), one quotient bit
// per enabled cycle. Define FACE_DETECT_SDIV_REM_EN to add the remainder port.
module face_detect_sdiv_25s_9s_seq #(
    parameter int ID         = 32'd1,
    parameter int din0_WIDTH = 32'd25,
    parameter int din1_WIDTH = 32'd9,
    parameter int dout_WIDTH = 32'd25
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
`ifdef FACE_DETECT_SDIV_REM_EN
    output logic [din1_WIDTH-1:0] rem,
`endif
    output logic                  div0
);

    import face_detect_sdiv_pkg::*;

    // ID is only an instance tag; folding it in as zero keeps it referenced.
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1 + (ID - ID));

    state_t           state;
    logic [DVD_W-1:0] work;
    logic [DVS_W:0]   prem;
    logic [DVS_W:0]   dmag;
    logic [CNT_W-1:0] count;
    logic             q_neg;
    logic             zero_div;
`ifdef FACE_DETECT_SDIV_REM_EN
    logic             r_neg;
    logic [DVS_W-1:0] din0_low;
`endif

    logic [DVD_W-1:0] din0_mag;
    logic [DVS_W:0]   din1_ext;
    logic [DVS_W:0]   din1_mag;
    logic [DVS_W:0]   next_prem;
    logic             qbit;

    assign din0_mag = din0[DVD_W-1] ? (~din0 + 1'b1) : din0;
    assign din1_ext = {din1[DVS_W-1], din1};
    assign din1_mag = din1_ext[DVS_W] ? (~din1_ext + 1'b1) : din1_ext;

    face_detect_sdiv_step u_step (
        .prem         (prem),
        .dividend_bit (work[DVD_W-1]),
        .dmag         (dmag),
        .next_prem    (next_prem),
        .qbit         (qbit)
    );

    // work shifts dividend bits out of the top while quotient bits enter at the bottom.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            dout      <= '0;
            div0      <= 1'b0;
            work      <= '0;
            prem      <= '0;
            dmag      <= '0;
            count     <= '0;
            q_neg     <= 1'b0;
            zero_div  <= 1'b0;
`ifdef FACE_DETECT_SDIV_REM_EN
            rem       <= '0;
            r_neg     <= 1'b0;
            din0_low  <= '0;
`endif
        end else if (ce) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        work     <= din0_mag;
                        dmag     <= din1_mag;
                        prem     <= '0;
                        count    <= LAST;
                        q_neg    <= din0[DVD_W-1] ^ din1[DVS_W-1];
                        zero_div <= (din1 == '0);
`ifdef FACE_DETECT_SDIV_REM_EN
                        r_neg    <= din0[DVD_W-1];
                        din0_low <= din0[DVS_W-1:0];
`endif
                        state    <= (din1 == '0) ? FIX : CALC;
                    end
                end
                CALC: begin
                    prem <= next_prem;
                    work <= {work[DVD_W-2:0], qbit};
                    if (count == '0) begin
                        state <= FIX;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                FIX: begin
                    if (zero_div) begin
                        dout <= '0;
                        div0 <= 1'b1;
`ifdef FACE_DETECT_SDIV_REM_EN
                        rem  <= din0_low;
`endif
                    end else begin
                        dout <= q_neg ? (~work + 1'b1) : work;
                        div0 <= 1'b0;
`ifdef FACE_DETECT_SDIV_REM_EN
                        rem  <= r_neg ? (~prem[DVS_W-1:0] + 1'b1) : prem[DVS_W-1:0];
`endif
                    end
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_face_detect_sdiv_25s_9s_seq.sv
// Directed self-checking bench for face_detect_sdiv_25s_9s_seq; remainder
// checks are active when FACE_DETECT_SDIV_REM_EN is defined.
module tb_face_detect_sdiv_25s_9s_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        ce;
    logic        in_valid;
    logic        in_ready;
    logic [24:0] din0;
    logic [8:0]  din1;
    logic        out_valid;
    logic        out_ready;
    logic [24:0] dout;
`ifdef FACE_DETECT_SDIV_REM_EN
    logic [8:0]  rem;
`endif
    logic        div0;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    face_detect_sdiv_25s_9s_seq dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
`ifdef FACE_DETECT_SDIV_REM_EN
        .rem       (rem),
`endif
        .div0      (div0)
    );

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        if (obs == exp) passed++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic acceptOperands(input int a, input int b);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) checkOutput("accept timeout", 0, 1);
        din0     = a[24:0];
        din1     = b[8:0];
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic waitResult(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 300) begin
            tick();
            cycles++;
        end
        if (!out_valid) checkOutput("result timeout", 0, 1);
    endtask

    task automatic applyStimulus(input string tag, input int a, input int b,
                                 input int exp_q, input int exp_r,
                                 input int exp_d0, input int exp_lat);
        int cycles;
        acceptOperands(a, b);
        waitResult(cycles);
        checkOutput({tag, " latency"}, cycles, exp_lat);
        checkOutput({tag, " dout"}, int'($signed(dout)), exp_q);
        checkOutput({tag, " div0"}, int'(div0), exp_d0);
`ifdef FACE_DETECT_SDIV_REM_EN
        checkOutput({tag, " rem"}, int'($signed(rem)), exp_r);
`else
        if (exp_r > 1000) $display("[TB] note: %s remainder out of range", tag);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput({tag, " handoff valid"}, int'(out_valid), 0);
        checkOutput({tag, " handoff ready"}, int'(in_ready), 1);
    endtask

    initial begin
        int cycles;
        int seen;

        reset     = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        din0      = '0;
        din1      = '0;
        tick();
        tick();
        checkOutput("reset in_ready", int'(in_ready), 1);
        checkOutput("reset out_valid", int'(out_valid), 0);
        checkOutput("reset dout", int'(dout), 0);
        checkOutput("reset div0", int'(div0), 0);
`ifdef FACE_DETECT_SDIV_REM_EN
        checkOutput("reset rem", int'(rem), 0);
`endif
        reset = 1'b0;
        tick();

        applyStimulus("p/p", 1000, 7, 142, 6, 0, 26);
        checkOutput("held dout", int'($signed(dout)), 142);
        applyStimulus("n/p", -1000, 7, -142, -6, 0, 26);
        applyStimulus("p/n", 1000, -7, -142, 6, 0, 26);
        applyStimulus("n/n", -1000, -7, 142, -6, 0, 26);
        applyStimulus("div0", 12345, 0, 0, 57, 1, 1);
        applyStimulus("minint", -16777216, -1, -16777216, 0, 0, 26);
        applyStimulus("maxint", 16777215, -256, -65535, 255, 0, 26);

        // 7777 / -13: ce toggles every cycle, so latency doubles exactly.
        acceptOperands(7777, -13);
        cycles = 0;
        while (!out_valid && cycles < 300) begin
            ce = cycles[0];
            tick();
            cycles++;
            if (cycles == 20) checkOutput("stall in_ready", int'(in_ready), 0);
        end
        ce = 1'b1;
        checkOutput("stall latency", cycles, 52);
        checkOutput("stall dout", int'($signed(dout)), -598);
`ifdef FACE_DETECT_SDIV_REM_EN
        checkOutput("stall rem", int'($signed(rem)), 3);
`endif
        din0     = 25'd50;
        din1     = 9'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        in_valid = 1'b0;
        checkOutput("backpressure valid", int'(out_valid), 1);
        checkOutput("backpressure in_ready", int'(in_ready), 0);
        checkOutput("backpressure dout", int'($signed(dout)), -598);
        ce        = 1'b0;
        out_ready = 1'b1;
        tick();
        checkOutput("ce0 holds valid", int'(out_valid), 1);
        ce = 1'b1;
        tick();
        out_ready = 1'b0;
        checkOutput("ce1 handoff valid", int'(out_valid), 0);
        checkOutput("ce1 handoff ready", int'(in_ready), 1);

        // Abort a division mid-flight and confirm nothing emerges from it.
        acceptOperands(5000, 3);
        for (int i = 0; i < 10; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkOutput("abort out_valid", int'(out_valid), 0);
        checkOutput("abort in_ready", int'(in_ready), 1);
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (out_valid) seen++;
        end
        checkOutput("abort no result", seen, 0);
        applyStimulus("after abort", 100, 3, 33, 1, 0, 26);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/face_detect_sdiv_25s_9s_seq.md
# face_detect_sdiv_25s_9s_seq

Iterative signed divider, the inverse of the face-detect 16ns×9s→25 pipelined multiplier: takes a 25-bit signed product-domain value and a 9-bit signed coefficient and recovers a 25-bit signed quotient (optionally a remainder). It is used where scaled window sums must be normalised back by the classifier coefficient. Radix-2 restoring, one quotient bit per enabled cycle, valid/ready handshake on both sides, global `ce` stall.

## Interface
- `ID`, 32'd1: instance tag, no functional effect
- `din0_WIDTH`, 32'd25: dividend width; must be 25
- `din1_WIDTH`, 32'd9: divisor width; must be 9
- `dout_WIDTH`, 32'd25: quotient width; must be 25

- `clk` in 1: clock, rising edge
- `reset` in 1: synchronous, active-high reset
- `ce` in 1: clock enable; when low, all state, counters and outputs hold
- `in_valid` in 1: operand pair valid
- `in_ready` out 1: block idle, will accept
- `din0` in 25: signed dividend
- `din1` in 9: signed divisor
- `out_valid` out 1: result valid
- `out_ready` in 1: consumer accepts result
- `dout` out 25: signed quotient, truncated toward zero
- `rem` out 9: signed remainder, sign of dividend (only with `FACE_DETECT_SDIV_REM_EN`)
- `div0` out 1: divisor was zero

## Operation
- FSM states: IDLE, CALC, FIX, DONE. Reset → IDLE.
- IDLE: `in_ready`=1. On `ce & in_valid`: latch |din0| (25b magnitude, zero-extended to 26b), |din1| (9b magnitude, extended to 10b), sign bits; count←24; → CALC.
- Divisor zero at accept: skip CALC, `dout`=0, `rem`=din0[8:0], `div0`=1, → DONE.
- CALC: per `ce` cycle shift partial remainder left, bring in next dividend MSB, trial subtract magnitude divisor; non-negative → keep, quotient bit 1; else restore, bit 0. After count=0 → FIX.
- FIX: quotient negated if sign(din0)≠sign(din1); remainder negated if din0<0. Result truncated to 25b (two's-complement wrap): −16777216 / −1 yields −16777216, rem 0, `div0`=0. → DONE.
- DONE: `out_valid`=1, outputs stable; on `ce & out_ready` → IDLE. No accept in the same cycle as result handoff (`in_ready` only in IDLE).
- |remainder| < |divisor| always; q·d + r = dividend for all non-overflow, non-zero-divisor cases.

## Timing
- Reset values: `in_ready`=1, `out_valid`=0, `dout`=0, `rem`=0, `div0`=0, state IDLE.
- Latency (ce held high): accept at edge N; `out_valid` asserted after edge N+26 (25 CALC + 1 FIX). Div-by-zero: `out_valid` after edge N+1.
- Throughput: one division per 27 cycles minimum plus handoff cycle.
- `ce`=0 freezes every register including handshake outputs; transactions complete only on cycles with `ce`=1.
- `reset` overrides `ce` and aborts any division in progress; no result emitted for the aborted operand.
- `dout`/`rem`/`div0` are held from FIX until next accept.

## Configuration
- `FACE_DETECT_SDIV_REM_EN` defined: `rem` port present and driven as above.
- Undefined: `rem` port absent; remainder sign-fix logic removed; quotient behaviour and latency unchanged.

## Structure
- Package `face_detect_sdiv_pkg`: state enum (IDLE/CALC/FIX/DONE), width constants (25, 9), iteration count constant 25.
- Sub-module `face_detect_sdiv_step`: combinational one-bit restoring step (partial rem, next dividend bit, divisor magnitude → new rem, quotient bit); top holds FSM, counter and sign handling.

## Test plan
- 1000 / 7 → `dout`=142, `rem`=6, `div0`=0, `out_valid` 26 cycles after accept.
- −1000 / 7 → −142, rem −6; 1000 / −7 → −142, rem 6; −1000 / −7 → 142, rem −6.
- 12345 / 0 → `div0`=1, `dout`=0, `rem`=12345[8:0]=57, `out_valid` 1 cycle after accept.
- −16777216 / −1 → `dout`=−16777216, rem 0; 16777215 / −256 → −65535, rem 255.
- `out_ready` low 10 cycles in DONE, `ce` toggled 50% during CALC → outputs stable, `in_ready`=0, result unchanged, latency stretches by stalled cycles exactly.
- `reset` pulsed mid-CALC → next cycle IDLE, `out_valid`=0, `in_ready`=1; following 100 / 3 → 33, rem 1.
